// File: rtl/arb_pkg.sv
// Shared definitions for the stream arbiter/multiplexer: FSM state
// encoding and the constant functions used to size port-index fields.
package arb_pkg;

    // Arbiter FSM states. IDLE spends one cycle choosing a port; LOCK
    // holds that port on the output until its last beat is accepted.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a port index field; never narrower than one bit.
    function automatic int port_width(input int num_ports);
        int w;
        w = clog2(num_ports);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: returns the first asserted request at or after
// ptr, wrapping modulo N. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] sel,
    output logic          any
);

    int idx_s;

    // Scan offsets from the farthest to the nearest so the nearest
    // requester at or after ptr is the one left standing in sel.
    always_comb begin
        sel   = '0;
        any   = 1'b0;
        idx_s = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = int'(ptr) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (req[idx_s]) begin
                sel = PW'(idx_s);
                any = 1'b1;
            end else begin
                sel = sel;
                any = any;
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-locked round-robin stream multiplexer. One IDLE cycle chooses
// a port; the chosen port then owns the output, with a zero-latency
// combinational datapath, until its last beat is accepted.
module stream_arb_mux
    import arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    localparam int PORT_W    = port_width(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS-1:0]            s_last,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic                            m_valid,
    output logic                            m_last,
    output logic [DATA_WIDTH-1:0]           m_data,
    input  logic                            m_ready,
    output logic [PORT_W-1:0]               m_port,
    output logic                            busy
);

    arb_state_e        state_q;
    logic [PORT_W-1:0] ptr_q;
    logic [PORT_W-1:0] gnt_q;
    logic [PORT_W-1:0] ptr_d;
    logic [PORT_W-1:0] pick_sel_s;
    logic              pick_any_s;
    logic              lock_s;
    logic              xfer_s;

    rr_pick #(
        .N  (NUM_PORTS),
        .PW (PORT_W)
    ) u_rr_pick (
        .req (s_valid),
        .ptr (ptr_q),
        .sel (pick_sel_s),
        .any (pick_any_s)
    );

    // Output is driven only while locked and not being reset, so the
    // upstream never sees s_ready during reset even if LOCK was active.
    assign lock_s = (state_q == ST_LOCK) && !rst;
    assign xfer_s = m_valid && m_ready;
    assign busy   = (state_q == ST_LOCK);
    assign m_port = gnt_q;

    // Pointer that follows the current grant, wrapping to port 0.
    always_comb begin
        ptr_d = gnt_q + PORT_W'(1);
        if (gnt_q == PORT_W'(NUM_PORTS - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_q + PORT_W'(1);
        end
    end

    // Pass the granted port straight through while locked; park at zero otherwise.
    always_comb begin
        s_ready = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        if (lock_s) begin
            m_valid        = s_valid[gnt_q];
            m_last         = s_last[gnt_q];
            m_data         = s_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
            s_ready[gnt_q] = m_ready;
        end else begin
            s_ready = '0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_data  = '0;
        end
    end

    // Arbitration FSM: grant in IDLE, release on the accepted last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        gnt_q   <= pick_sel_s;
                        state_q <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (xfer_s && m_last) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Self-checking bench for stream_arb_mux: packet sources per port, a
// packet-level arbitration model, a per-port beat scoreboard, and
// directed scenarios with hand-computed expectations.
module tb_stream_arb_mux;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_valid, s_last, s_ready;
    logic [N*DW-1:0] s_data;
    logic            m_valid, m_last, m_ready, busy;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_port;

    always #5 clk = ~clk;

    stream_arb_mux #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_ready(m_ready),
        .m_port(m_port), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // Sources: seq = index of the beat currently offered, rem = beats left in packet.
    int seq[N];
    int rem[N];
    int rx_seq[N];
    bit [N-1:0] en_mask;
    int plen_cfg, vprob, rprob, rst_prob;
    bit rst_req;

    // Model: who owns the output and where the next search starts.
    bit mlock;
    int mown, mptr;

    int dlog[$];
    bit prev_busy;
    logic [N-1:0]  smp_sready;
    logic          smp_mv, smp_busy, smp_last;
    logic [1:0]    smp_port;
    logic [DW-1:0] smp_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input int p, input int s);
        return {8'(p), 24'(s)};
    endfunction

    // One clock: drive at negedge, compare 1ns later, update at posedge.
    task automatic cycle();
        logic ev, el;
        logic [N-1:0] er;
        logic [DW-1:0] ed;
        bit xf;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && en_mask[i])
                rem[i] = (plen_cfg == 0) ? int'($urandom_range(4, 1)) : plen_cfg;
            s_valid[i] = (rem[i] > 0) && ($urandom_range(99) < vprob);
            s_last[i]  = (rem[i] == 1);
            s_data[i*DW +: DW] = beat_word(i, seq[i]);
        end
        m_ready = ($urandom_range(99) < rprob);
        rst = rst_req || ($urandom_range(999) < rst_prob);
        #1;
        ev = 1'b0; el = 1'b0; er = '0; ed = '0;
        if (mlock) begin
            el = s_last[mown];
            ed = s_data[mown*DW +: DW];
            if (!rst) begin
                ev = s_valid[mown];
                er[mown] = m_ready;
            end
        end
        chk("m_valid", m_valid, ev);
        chk("s_ready", s_ready, er);
        chk("busy", busy, mlock);
        chk("m_port", m_port, mown);
        if (!rst && (!mlock || ev)) begin
            chk("m_data", m_data, ed);
            chk("m_last", m_last, el);
        end
        xf = ev && m_ready;
        if (xf) begin
            chk("beat_order", m_data, beat_word(mown, rx_seq[mown]));
            rx_seq[mown]++;
        end
        if (busy && !prev_busy) dlog.push_back(int'(m_port));
        prev_busy  = busy;
        smp_sready = s_ready; smp_mv = m_valid; smp_busy = busy;
        smp_last   = m_last;  smp_port = m_port; smp_data = m_data;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (s_valid[i] && smp_sready[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        if (rst) begin
            mlock = 1'b0; mown = 0; mptr = 0;
        end else if (!mlock) begin
            for (int k = 0; k < N; k++) begin
                if (s_valid[(mptr + k) % N]) begin
                    mown  = (mptr + k) % N;
                    mlock = 1'b1;
                    break;
                end
            end
        end else if (xf && s_last[mown]) begin
            mlock = 1'b0;
            mptr  = (mown + 1) % N;
        end
    endtask

    task automatic reset_dut();
        rst_req = 1'b1;
        en_mask = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        cycle();
        cycle();
        rst_req = 1'b0;
    endtask

    initial begin
        int base, start;
        bit drained;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; rem[i] = 0; rx_seq[i] = 0;
        end
        rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
        rst_req = 1'b0; rst_prob = 0; en_mask = '0;
        plen_cfg = 1; vprob = 100; rprob = 100;
        mlock = 1'b0; mown = 0; mptr = 0; prev_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then port 2 sends a 3-beat packet.
        reset_dut();
        chk("reset_busy", smp_busy, 1'b0);
        chk("reset_port", smp_port, 2'd0);
        chk("reset_valid", smp_mv, 1'b0);
        plen_cfg = 3; en_mask = 4'b0100;
        cycle();
        en_mask = '0;
        chk("A.c0_idle", smp_busy, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            cycle();
            chk("A.beat_valid", smp_mv, 1'b1);
            chk("A.port", smp_port, 2'd2);
            chk("A.last", smp_last, (c == 3));
        end
        cycle();
        chk("A.c4_idle", smp_busy, 1'b0);

        // Pointer now 3: ports 0 and 1 request, wrap selects 0 then 1.
        dlog.delete();
        plen_cfg = 1; en_mask = 4'b0011;
        cycle();
        en_mask = '0;
        repeat (3) cycle();
        chk("wrap.count", dlog.size(), 2);
        if (dlog.size() >= 2) begin
            chk("wrap.first", dlog[0], 0);
            chk("wrap.second", dlog[1], 1);
        end

        // Reset during the 2nd beat of a 4-beat packet from port 1 (ptr is 2 here).
        plen_cfg = 4; en_mask = 4'b0010;
        cycle();
        en_mask = '0;
        cycle();
        rst_req = 1'b1;
        cycle();
        chk("rst.m_valid", smp_mv, 1'b0);
        chk("rst.s_ready", smp_sready, 4'b0000);
        rst_req = 1'b0;
        rem[1] = 0;
        dlog.delete();
        plen_cfg = 1; en_mask = 4'b1001;
        cycle();
        en_mask = '0;
        chk("rst.after_busy", smp_busy, 1'b0);
        chk("rst.after_port", smp_port, 2'd0);
        repeat (4) cycle();
        chk("rst.grant_count", dlog.size(), 2);
        if (dlog.size() >= 2) begin
            chk("rst.grant0", dlog[0], 0);
            chk("rst.grant1", dlog[1], 3);
        end

        // Port 1 mid-packet, port 0 requests and must wait.
        reset_dut();
        dlog.delete();
        plen_cfg = 3; en_mask = 4'b0010;
        cycle();
        en_mask = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            cycle();
            en_mask = '0;
            chk("C.port0_blocked", smp_sready[0], 1'b0);
            chk("C.owner", smp_port, 2'd1);
        end
        repeat (5) cycle();
        chk("C.grant_count", dlog.size(), 2);
        if (dlog.size() >= 2) begin
            chk("C.grant0", dlog[0], 1);
            chk("C.grant1", dlog[1], 0);
        end

        // Downstream stall of 5 cycles mid-packet.
        reset_dut();
        start = rx_seq[2];
        plen_cfg = 4; en_mask = 4'b0100;
        cycle();
        en_mask = '0;
        cycle();
        base = seq[2];
        rprob = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("D.stall_ready", smp_sready, 4'b0000);
            chk("D.stall_valid", smp_mv, 1'b1);
            chk("D.stall_data", smp_data, beat_word(2, base));
        end
        rprob = 100;
        repeat (4) cycle();
        chk("D.beats", rx_seq[2] - start, 4);
        chk("D.done", rem[2], 0);

        // All ports continuously offering single-beat packets.
        reset_dut();
        dlog.delete();
        plen_cfg = 1; en_mask = 4'b1111;
        repeat (10) cycle();
        chk("B.count", dlog.size(), 5);
        if (dlog.size() >= 5) begin
            chk("B.g0", dlog[0], 0);
            chk("B.g1", dlog[1], 1);
            chk("B.g2", dlog[2], 2);
            chk("B.g3", dlog[3], 3);
            chk("B.g4", dlog[4], 0);
        end

        // Randomized traffic with occasional resets.
        reset_dut();
        plen_cfg = 0; en_mask = 4'b1111; vprob = 70; rprob = 70; rst_prob = 5;
        repeat (3000) cycle();
        en_mask = 4'b1010; vprob = 40; rprob = 50;
        repeat (1000) cycle();
        rst_prob = 0; en_mask = '0; vprob = 100; rprob = 100;
        drained = 1'b0;
        for (int c = 0; c < 200 && !drained; c++) begin
            cycle();
            drained = 1'b1;
            for (int i = 0; i < N; i++) if (rem[i] != 0) drained = 1'b0;
        end
        chk("drain_done", drained, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
